fb_rect_writer: RTL and testbench
=================================

Name: fb_rect_writer

Overview:
- Write-side producer for the 160x120 pixel frame buffer that the VGA read path scans.
- Accepts one fill-rectangle command at a time (origin, size, colour) over a valid/ready handshake.
- Clips the rectangle to the image bounds and emits one write per cycle: linear address y*IMG_WIDTH+x plus colour.
- Sits between game/board drawing logic (grid cells, ship markers, hit/miss marks) and the frame-buffer BRAM write port.

Parameters:
- IMG_WIDTH, 160, frame-buffer width in pixels.
- IMG_HEIGHT, 120, frame-buffer height in pixels.
- COLOR_W, 12, pixel data width (RGB444).
- ADDR_W, 17, frame-buffer address width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_x0  input  10  rectangle left column.
- cmd_y0  input  10  rectangle top row.
- cmd_w  input  10  rectangle width in pixels.
- cmd_h  input  10  rectangle height in pixels.
- cmd_color  input  COLOR_W  fill colour.
- wr_en  output  1  write request to frame buffer.
- wr_ready  input  1  frame buffer accepts the write this cycle.
- wr_addr  output  ADDR_W  linear pixel address.
- wr_data  output  COLOR_W  pixel colour.
- busy  output  1  command in progress (any state other than IDLE).
- done  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; wr_en=0, wr_addr=0, wr_data=0, done=0, busy=0.
  - Any in-flight command is abandoned with no further writes.
  - cmd_ready=1 once rst is released.
- cmd_ready = (state==IDLE), combinational. A handshake occurs at a rising edge with cmd_valid&&cmd_ready; all cmd_* fields are latched then.
- cmd_valid in any other state is ignored: no latch, no queueing.
- States:
  - IDLE: on handshake -> CLIP.
  - CLIP, one cycle:
    - x_end = min(x0+w, IMG_WIDTH), y_end = min(y0+h, IMG_HEIGHT); 11-bit sums, no overflow.
    - Empty if w==0, h==0, x0>=IMG_WIDTH or y0>=IMG_HEIGHT -> DONE.
    - Otherwise cur_x=x0, cur_y=y0, row_base=y0*IMG_WIDTH -> FILL.
  - FILL:
    - wr_en=1, wr_addr=row_base+cur_x, wr_data=latched colour.
    - At an edge with wr_ready=1: if cur_x==x_end-1, then cur_x<=x0, cur_y<=cur_y+1, row_base<=row_base+IMG_WIDTH; else cur_x<=cur_x+1.
    - Accepted write with cur_x==x_end-1 and cur_y==y_end-1 -> DONE.
    - wr_ready=0: wr_en, wr_addr and wr_data hold unchanged; no advance.
  - DONE: done=1 for exactly one cycle, wr_en=0 -> IDLE.
- Row base is maintained by accumulation; the only multiply is the single y0*IMG_WIDTH in CLIP.
- Write order: row-major, left to right, top to bottom.
- Max address IMG_WIDTH*IMG_HEIGHT-1 = 19199. No address outside [0,19199] is ever issued.
- Latency:
  - Handshake at edge T; CLIP during cycle T..T+1; first wr_en at T+1 (after that edge).
  - With wr_ready held 1, an N-pixel clipped rectangle writes for N cycles, then done for one cycle, then cmd_ready=1.
  - Handshake to next cmd_ready = N+2 cycles.
- Empty command: no wr_en; done pulses 2 cycles after handshake.
- wr_en is never asserted outside FILL; done is never asserted together with wr_en.

Test Plan:
- Basic fill: x0=2, y0=3, w=3, h=2, color=12'hF00, wr_ready=1 -> writes 482,483,484,642,643,644, all data F00; 6 consecutive wr_en cycles, then done pulse, then cmd_ready=1.
- Corner clip: x0=158, y0=118, w=5, h=5, color=12'h0F0 -> exactly 4 writes: 19038,19039,19198,19199; done follows.
- Empty/off-screen: w=0 (x0=10,y0=10,h=4), then x0=200 (w=4,h=4) -> no wr_en for either; done 2 cycles after each handshake.
- Backpressure: x0=0, y0=0, w=4, h=1, wr_ready pattern 1,0,0,1,1,0,1 -> addr 0,1,1,1,2,3,3 with wr_en held; each address written once; addr/data stable while wr_ready=0.
- Busy rejection: during the basic-fill command, pulse cmd_valid with x0=50 -> cmd_ready=0 and command ignored; only the original 6 addresses written.
- Reset mid-fill: full-screen fill (0,0,160,120), assert rst=0 after 100 writes -> wr_en, done, busy = 0 immediately (async); after release cmd_ready=1 and no further writes until a new command.

Source files
------------

// File: rtl/fb_rect_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fb_rect_writer
// Description : Fill-rectangle write producer for a 160x120 frame buffer.
//               Accepts one rectangle command at a time (origin, size,
//               colour), clips it to the image bounds and streams one
//               write per accepted cycle in row-major order.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low (0 = reset)
//   cmd_valid  command present
//   cmd_ready  block idle and able to accept a command
//   cmd_x0     rectangle left column
//   cmd_y0     rectangle top row
//   cmd_w      rectangle width in pixels
//   cmd_h      rectangle height in pixels
//   cmd_color  fill colour
//   wr_en      write request to the frame buffer
//   wr_ready   frame buffer accepts the write this cycle
//   wr_addr    linear pixel address y*IMG_WIDTH + x
//   wr_data    pixel colour
//   busy       command in progress
//   done       one-cycle pulse when a command completes
// ============================================================================
module fb_rect_writer #(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120,
    parameter int COLOR_W    = 12,
    parameter int ADDR_W     = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [9:0]         cmd_x0,
    input  logic [9:0]         cmd_y0,
    input  logic [9:0]         cmd_w,
    input  logic [9:0]         cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic               wr_en,
    input  logic               wr_ready,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               busy,
    output logic               done
);

    localparam logic [10:0]       c_IMG_W      = 11'(IMG_WIDTH);
    localparam logic [10:0]       c_IMG_H      = 11'(IMG_HEIGHT);
    localparam logic [ADDR_W-1:0] c_ROW_STRIDE = ADDR_W'(IMG_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLIP = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Latched command
    logic [9:0]         r_x0;
    logic [9:0]         r_y0;
    logic [9:0]         r_w;
    logic [9:0]         r_h;
    logic [COLOR_W-1:0] r_color;

    // Clipped bounds (exclusive) and scan position
    logic [10:0]        r_x_end;
    logic [10:0]        r_y_end;
    logic [9:0]         r_cur_x;
    logic [9:0]         r_cur_y;
    logic [ADDR_W-1:0]  r_row_base;

    logic               w_handshake;
    logic               w_accept;
    logic [10:0]        w_x_sum;
    logic [10:0]        w_y_sum;
    logic [10:0]        w_x_end;
    logic [10:0]        w_y_end;
    logic               w_empty;
    logic               w_last_col;
    logic               w_last_row;
    logic [ADDR_W-1:0]  w_first_row_base;

    assign w_handshake = (r_state == S_IDLE) && cmd_valid;
    assign w_accept    = (r_state == S_FILL) && wr_ready;

    // 11-bit sums cannot overflow for 10-bit operands.
    assign w_x_sum = {1'b0, r_x0} + {1'b0, r_w};
    assign w_y_sum = {1'b0, r_y0} + {1'b0, r_h};
    assign w_x_end = (w_x_sum > c_IMG_W) ? c_IMG_W : w_x_sum;
    assign w_y_end = (w_y_sum > c_IMG_H) ? c_IMG_H : w_y_sum;

    assign w_empty = (r_w == 10'd0) || (r_h == 10'd0) ||
                     ({1'b0, r_x0} >= c_IMG_W) || ({1'b0, r_y0} >= c_IMG_H);

    // The only multiply; every later row base is reached by accumulation.
    // The product may wrap for off-screen y0, but that case never enters FILL.
    assign w_first_row_base = ADDR_W'(r_y0) * c_ROW_STRIDE;

    assign w_last_col = ({1'b0, r_cur_x} == (r_x_end - 11'd1));
    assign w_last_row = ({1'b0, r_cur_y} == (r_y_end - 11'd1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_handshake) begin
                    w_state_next = S_CLIP;
                end
            end
            S_CLIP: begin
                w_state_next = w_empty ? S_DONE : S_FILL;
            end
            S_FILL: begin
                if (w_accept && w_last_col && w_last_row) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command latch and scan datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x0       <= '0;
            r_y0       <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_color    <= '0;
            r_x_end    <= '0;
            r_y_end    <= '0;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_row_base <= '0;
        end else begin
            if (w_handshake) begin
                r_x0    <= cmd_x0;
                r_y0    <= cmd_y0;
                r_w     <= cmd_w;
                r_h     <= cmd_h;
                r_color <= cmd_color;
            end

            if (r_state == S_CLIP) begin
                r_x_end    <= w_x_end;
                r_y_end    <= w_y_end;
                r_cur_x    <= r_x0;
                r_cur_y    <= r_y0;
                r_row_base <= w_first_row_base;
            end

            if (w_accept) begin
                if (w_last_col) begin
                    r_cur_x    <= r_x0;
                    r_cur_y    <= r_cur_y + 10'd1;
                    r_row_base <= r_row_base + c_ROW_STRIDE;
                end else begin
                    r_cur_x    <= r_cur_x + 10'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state so reset clears them immediately and a
    // stalled write holds naturally while the scan position is frozen.
    // ------------------------------------------------------------------
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign wr_en     = (r_state == S_FILL);
    assign done      = (r_state == S_DONE);
    assign wr_addr   = wr_en ? (r_row_base + ADDR_W'(r_cur_x)) : '0;
    assign wr_data   = wr_en ? r_color : '0;

endmodule
`default_nettype wire

// File: tb/tb_fb_rect_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fb_rect_writer
// Description : Scoreboard testbench for fb_rect_writer. Commands push the
//               expected write/done sequence from a pixel-loop reference
//               model; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_rect_writer;

    localparam int IMG_WIDTH  = 160;
    localparam int IMG_HEIGHT = 120;
    localparam int COLOR_W    = 12;
    localparam int ADDR_W     = 17;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [9:0]         cmd_x0 = '0;
    logic [9:0]         cmd_y0 = '0;
    logic [9:0]         cmd_w = '0;
    logic [9:0]         cmd_h = '0;
    logic [COLOR_W-1:0] cmd_color = '0;
    logic               wr_en;
    logic               wr_ready = 1'b1;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COLOR_W-1:0] wr_data;
    logic               busy;
    logic               done;

    fb_rect_writer #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT),
        .COLOR_W   (COLOR_W),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_x0   (cmd_x0),
        .cmd_y0   (cmd_y0),
        .cmd_w    (cmd_w),
        .cmd_h    (cmd_h),
        .cmd_color(cmd_color),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // ------------------------------------------------------------------
    // Frame-buffer backpressure generator: 0 = always ready,
    // 1 = random, 2 = fixed 7-cycle pattern starting at cycle bp_start.
    // ------------------------------------------------------------------
    int         bp_mode  = 0;
    int         bp_start = 32'h7fff_ffff;
    logic [6:0] bp_pat   = 7'b1011001;   // cycle order 1,0,0,1,1,0,1

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            1: wr_ready = ($urandom_range(3) != 0);
            2: begin
                if (cyc >= bp_start && cyc < bp_start + 7) wr_ready = bp_pat[cyc - bp_start];
                else wr_ready = 1'b1;
            end
            default: wr_ready = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        bit is_done;
        int addr;
        int data;
        int cyc;     // expected done cycle, -1 when not timed
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_acc = 0;
    bit  prev_stall = 1'b0;
    int  prev_addr  = 0;
    int  prev_data  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            prev_stall <= 1'b0;
        end else begin
            if (wr_en && done) chk("wr_en_with_done", 1, 0);
            if (prev_stall) begin
                chk("stall_hold_en", int'(wr_en), 1);
                chk("stall_hold_addr", int'(wr_addr), prev_addr);
                chk("stall_hold_data", int'(wr_data), prev_data);
            end
            if (wr_en && wr_ready) begin
                n_acc <= n_acc + 1;
                if (exp_q.size() == 0) begin
                    chk("extra_write_addr", int'(wr_addr), -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.is_done) begin
                        chk("write_before_done", int'(wr_addr), -1);
                    end else begin
                        chk("wr_addr", int'(wr_addr), mon_e.addr);
                        chk("wr_data", int'(wr_data), mon_e.data);
                    end
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("extra_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (!mon_e.is_done) chk("done_early_missing_addr", mon_e.addr, -1);
                    else if (mon_e.cyc >= 0) chk("done_cycle", cyc, mon_e.cyc);
                end
            end
            prev_stall <= wr_en && !wr_ready;
            prev_addr  <= int'(wr_addr);
            prev_data  <= int'(wr_data);
        end
    end

    // ------------------------------------------------------------------
    // Reference model: visit every pixel of the requested rectangle in
    // row-major order and keep those that land inside the image.
    // ------------------------------------------------------------------
    task automatic model_push(input int x0, input int y0, input int w, input int h,
                              input int color, input bit timed, input int e);
        int n = 0;
        for (int y = y0; y < y0 + h; y++) begin
            for (int x = x0; x < x0 + w; x++) begin
                if (x < IMG_WIDTH && y < IMG_HEIGHT) begin
                    exp_q.push_back('{1'b0, y * IMG_WIDTH + x, color, -1});
                    n++;
                end
            end
        end
        exp_q.push_back('{1'b1, 0, 0, timed ? (e + n + 1) : -1});
    endtask

    // Present a command and hold it until the handshake edge; e is the
    // cycle number of that edge.
    task automatic send_cmd(input int x0, input int y0, input int w, input int h,
                            input int color, input bit timed, output int e);
        int i;
        e = -1;
        @(posedge clk); #1;
        cmd_x0    = 10'(x0);
        cmd_y0    = 10'(y0);
        cmd_w     = 10'(w);
        cmd_h     = 10'(h);
        cmd_color = COLOR_W'(color);
        cmd_valid = 1'b1;
        for (i = 0; i < 50000; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        if (i == 50000) begin
            chk("cmd_ready_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        e = cyc + 1;
        model_push(x0, y0, w, h, color, timed, e);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && cmd_ready) break;
        end
        if (i == budget) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int e;
        int start;
        int i;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_wr_en", int'(wr_en), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_wr_addr", int'(wr_addr), 0);
        chk("reset_wr_data", int'(wr_data), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_cmd_ready", int'(cmd_ready), 1);

        // Basic fill, with a rejected command pulsed while busy
        send_cmd(2, 3, 3, 2, 12'hF00, 1'b1, e);
        cmd_x0    = 10'd50;
        cmd_color = 12'h00F;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("busy_cmd_ready_clip", int'(cmd_ready), 0);
        @(negedge clk);
        chk("busy_cmd_ready_fill", int'(cmd_ready), 0);
        chk("busy_flag", int'(busy), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle(200);

        // Bottom-right corner clip
        send_cmd(158, 118, 5, 5, 12'h0F0, 1'b1, e);
        wait_idle(200);

        // Empty and off-screen commands
        send_cmd(10, 10, 0, 4, 12'h123, 1'b1, e);
        wait_idle(200);
        send_cmd(200, 10, 4, 4, 12'h456, 1'b1, e);
        wait_idle(200);
        send_cmd(10, 130, 4, 4, 12'h789, 1'b1, e);
        wait_idle(200);

        // Fixed backpressure pattern
        bp_mode = 2;
        send_cmd(0, 0, 4, 1, 12'hABC, 1'b0, e);
        bp_start = e + 1;
        wait_idle(200);
        bp_mode  = 0;
        bp_start = 32'h7fff_ffff;

        // Randomised commands under random backpressure
        bp_mode = 1;
        for (int k = 0; k < 30; k++) begin
            send_cmd($urandom_range(175), $urandom_range(127), $urandom_range(24),
                     $urandom_range(16), $urandom_range(4095), 1'b0, e);
            wait_idle(5000);
        end
        bp_mode = 0;
        @(posedge clk);

        // Asynchronous reset in the middle of a full-screen fill
        send_cmd(0, 0, 160, 120, 12'hFFF, 1'b1, e);
        start = n_acc;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (n_acc - start >= 100) break;
        end
        if (i == 400) chk("fill_progress_timeout", 0, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_wr_en", int'(wr_en), 0);
        chk("async_reset_done", int'(done), 0);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_wr_addr", int'(wr_addr), 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_after_reset_ready", int'(cmd_ready), 1);
            chk("idle_after_reset_wr_en", int'(wr_en), 0);
        end
        send_cmd(5, 5, 2, 2, 12'h5A5, 1'b1, e);
        wait_idle(200);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
